// File: rtl/hex_line_writer.sv
// hex_line_writer: prints a 32-bit word as an ASCII hex line into tx_pipe.
// Option macro HEX_LINE_WRITER_CRLF_EN: CR LF terminator instead of LF only.
module hex_line_writer #(
  parameter int NIBBLES = 8,
  parameter bit UPPER   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] word,
  output logic        ready,
  output logic        done,
  output logic        push_back,
  output logic [7:0]  data_out,
  input  logic        full
);

`ifdef HEX_LINE_WRITER_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 1;
`endif
  localparam int LINE_LEN = NIBBLES + TERM_LEN;
  localparam int ALIGN = 32 - 4 * NIBBLES;
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);
  localparam logic [3:0] NIB_CNT = 4'(NIBBLES);
  localparam logic [7:0] ALPHA_BASE = UPPER ? 8'h41 : 8'h61;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  idx_q, idx_d;
  logic        push_q, push_d;
  logic        done_q, done_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  digit;
  logic [7:0]  char_cur;

  // character at the current index: hex digit or terminator
  always_comb begin
    digit = shift_q[31:28];
    char_cur = 8'h0A;
    if (idx_q < NIB_CNT) begin
      if (digit < 4'd10) char_cur = 8'h30 + {4'h0, digit};
      else char_cur = ALPHA_BASE + {4'h0, digit} - 8'd10;
    end else begin
`ifdef HEX_LINE_WRITER_CRLF_EN
      char_cur = (idx_q == NIB_CNT) ? 8'h0D : 8'h0A;
`else
      char_cur = 8'h0A;
`endif
    end
  end

  // next state and registered outputs
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    push_d  = 1'b0;
    done_d  = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = word << ALIGN;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!full) begin
          push_d  = 1'b1;
          data_d  = char_cur;
          state_d = GAP;
        end
      end
      GAP: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          shift_d = shift_q << 4;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 32'h0;
      idx_q   <= 4'd0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      push_q  <= push_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign push_back = push_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_hex_line_writer.sv
// tb_hex_line_writer: vector table plus scoreboard for two parameterisations.
// Reset abort, backpressure and ignored restarts are exercised explicitly.
module tb_hex_line_writer;

`ifdef HEX_LINE_WRITER_CRLF_EN
  localparam int TERM = 2;
`else
  localparam int TERM = 1;
`endif
  localparam int N0 = 8;
  localparam int N1 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, full0 = 1'b0;
  logic [31:0] word0 = 32'h0;
  logic        ready0, done0, pb0;
  logic [7:0]  do0;
  logic        start1 = 1'b0, full1 = 1'b0;
  logic [31:0] word1 = 32'h0;
  logic        ready1, done1, pb1;
  logic [7:0]  do1;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic prev0 = 1'b0, prev1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hex_line_writer #(.NIBBLES(N0), .UPPER(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .word(word0),
    .ready(ready0), .done(done0), .push_back(pb0),
    .data_out(do0), .full(full0)
  );

  hex_line_writer #(.NIBBLES(N1), .UPPER(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .word(word1),
    .ready(ready1), .done(done1), .push_back(pb1),
    .data_out(do1), .full(full1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] d, input bit up);
    if (d < 4'd10) return 8'h30 + {4'h0, d};
    return (up ? 8'h41 : 8'h61) + {4'h0, d} - 8'd10;
  endfunction

  // expected line for an instance goes to its queue
  task automatic exp_line(input int sel, input logic [31:0] w);
    int n;
    logic [7:0] c;
    n = (sel != 0) ? N1 : N0;
    for (int i = 0; i < n; i++) begin
      c = hexc(w[4*(n-1-i) +: 4], sel == 0);
      if (sel != 0) q1.push_back(c);
      else q0.push_back(c);
    end
    for (int t = TERM; t > 0; t--) begin
      c = (t == 2) ? 8'h0D : 8'h0A;
      if (sel != 0) q1.push_back(c);
      else q0.push_back(c);
    end
  endtask

  // scoreboard: every push pops one expected character
  always @(negedge clk) begin
    if (pb0) begin
      chk("u0_back_to_back", 32'(prev0), 32'h0);
      if (q0.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL u0_extra_push: got %0h want none", do0);
      end else chk("u0_char", 32'(do0), 32'(q0.pop_front()));
    end
    if (pb1) begin
      chk("u1_back_to_back", 32'(prev1), 32'h0);
      if (q1.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL u1_extra_push: got %0h want none", do1);
      end else chk("u1_char", 32'(do1), 32'(q1.pop_front()));
    end
    prev0 = pb0;
    prev1 = pb1;
  end

  task automatic drive(input int sel, input logic s, input logic [31:0] w);
    if (sel != 0) begin start1 = s; word1 = w; end
    else begin start0 = s; word0 = w; end
  endtask

  task automatic set_full(input int sel, input logic f);
    if (sel != 0) full1 = f;
    else full0 = f;
  endtask

  // one line with optional initial stall and ignored restart
  task automatic run_line(input int sel, input logic [31:0] w,
                          input int stall, input bit restart,
                          input logic [7:0] first_exp);
    int n, len, np, first_c, last_c, done_c, rdy_err;
    bit got_done, rdy_done, pb, dn, rd;
    logic [7:0] fc, dv;
    n = (sel != 0) ? N1 : N0;
    len = n + TERM;
    np = 0; first_c = -1; last_c = -1; done_c = -1;
    rdy_err = 0; got_done = 0; rdy_done = 0; fc = 8'h00;
    @(negedge clk);
    drive(sel, 1'b1, w);
    if (stall > 0) set_full(sel, 1'b1);
    exp_line(sel, w);
    @(negedge clk);
    drive(sel, 1'b0, $urandom);
    for (int k = 0; k < 200 && !got_done; k++) begin
      pb = (sel != 0) ? pb1 : pb0;
      dn = (sel != 0) ? done1 : done0;
      rd = (sel != 0) ? ready1 : ready0;
      dv = (sel != 0) ? do1 : do0;
      if (pb) begin
        if (np == 0) begin first_c = k; fc = dv; end
        last_c = k;
        np++;
      end
      if (dn) begin
        got_done = 1;
        done_c = k;
        rdy_done = rd;
      end else if (rd) rdy_err++;
      if (k == stall) set_full(sel, 1'b0);
      if (restart && k == 3) drive(sel, 1'b1, 32'hFFFFFFFF);
      if (restart && k == 4) drive(sel, 1'b0, 32'h0);
      @(negedge clk);
    end
    chk("done_seen", 32'(got_done), 32'h1);
    chk("first_push_cyc", 32'(first_c), 32'(1 + stall));
    chk("last_push_cyc", 32'(last_c), 32'(2 * len - 1 + stall));
    chk("done_cyc", 32'(done_c), 32'(2 * len + stall));
    chk("push_count", 32'(np), 32'(len));
    chk("ready_low_in_line", 32'(rdy_err), 32'h0);
    chk("ready_at_done", 32'(rdy_done), 32'h1);
    chk("first_char", 32'(fc), 32'(first_exp));
    chk("queue_drained",
        32'((sel != 0) ? q1.size() : q0.size()), 32'h0);
    set_full(sel, 1'b0);
    if (sel != 0) q1.delete();
    else q0.delete();
  endtask

  typedef struct {
    int          sel;
    logic [31:0] w;
    int          stall;
    bit          rs;
    logic [7:0]  first;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int np;
    tbl[0] = '{0, 32'h1234ABCD, 0, 1'b0, 8'h31};
    tbl[1] = '{0, 32'h00000000, 0, 1'b0, 8'h30};
    tbl[2] = '{0, 32'h9A5C07E3, 0, 1'b0, 8'h39};
    tbl[3] = '{1, 32'h000000FE, 0, 1'b0, 8'h66};
    tbl[4] = '{1, 32'h1234563A, 0, 1'b0, 8'h33};
    tbl[5] = '{1, 32'h000000B7, 0, 1'b0, 8'h62};
    tbl[6] = '{0, 32'h0000000F, 5, 1'b0, 8'h30};
    tbl[7] = '{0, 32'hCAFE0123, 0, 1'b1, 8'h43};
    tbl[8] = '{1, 32'h0000000C, 3, 1'b1, 8'h30};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready0), 32'h1);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_push", 32'(pb0), 32'h0);
    chk("rst_data", 32'(do0), 32'h0);
    chk("rst_ready_u1", 32'(ready1), 32'h1);

    foreach (tbl[i])
      run_line(tbl[i].sel, tbl[i].w, tbl[i].stall,
               tbl[i].rs, tbl[i].first);

    // reset after the third push abandons the line
    @(negedge clk);
    drive(0, 1'b1, 32'h12345678);
    exp_line(0, 32'h12345678);
    @(negedge clk);
    drive(0, 1'b0, 32'h0);
    np = 0;
    for (int k = 0; k < 40; k++) begin
      if (pb0) np++;
      if (np == 3) break;
      @(negedge clk);
    end
    chk("third_push_seen", 32'(np), 32'h3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_push", 32'(pb0), 32'h0);
    chk("mid_rst_ready", 32'(ready0), 32'h1);
    chk("mid_rst_data", 32'(do0), 32'h0);
    chk("mid_rst_done", 32'(done0), 32'h0);
    np = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pb0) np++;
    end
    chk("no_push_after_rst", 32'(np), 32'h0);
    run_line(0, 32'h00000000, 0, 1'b0, 8'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
